// File: rtl/program_loader_if.sv
// Byte-source and instruction-memory write bundle for the program loader.
// The master modport is the loader side. The slave modport is the byte
// source plus the memory/CPU side.
interface program_loader_if #(
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 32
);
  logic                         byteValid;
  logic [7:0]                   byteIn;
  logic                         writeEnable;
  logic [PC_WIDTH-1:0]          writeAddress;
  logic [INSTRUCTION_WIDTH-1:0] writeData;
  logic                         cpuHold;
  logic                         loadDone;
  logic                         loadError;

  modport master (
    input  byteValid, byteIn,
    output writeEnable, writeAddress, writeData, cpuHold, loadDone, loadError
  );

  modport slave (
    output byteValid, byteIn,
    input  writeEnable, writeAddress, writeData, cpuHold, loadDone, loadError
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream and assembles it big-endian
// into instruction words. Each word is written to sequential instruction
// memory addresses. The CPU is held in reset until the frame checksum
// matches.
// Frame format: START_BYTE, N (word count), N words of data bytes (MSB
// first), then a checksum byte equal to N XOR all of the data bytes.
module program_loader #(
  parameter int         PC_WIDTH          = 8,
  parameter int         INSTRUCTION_WIDTH = 32,
  parameter logic [7:0] START_BYTE        = 8'hA5,
  parameter int         TIMEOUT_CYCLES    = 1000000
) (
  input  logic             clock,
  input  logic             isReset,
  program_loader_if.master bus
);

  localparam int BYTES_PER_WORD = INSTRUCTION_WIDTH / 8;
  localparam int BYTE_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int WORD_CNT_W     = PC_WIDTH + 1;
  localparam int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE    = BYTE_CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [TIMEOUT_W-1:0]  TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, ERROR} state_t;

  state_t                       state_q, state_d;
  logic [BYTE_CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [WORD_CNT_W-1:0]        word_cnt_q, word_cnt_d;
  logic [WORD_CNT_W-1:0]        word_total_q, word_total_d;
  logic [7:0]                   checksum_q, checksum_d;
  logic [TIMEOUT_W-1:0]         timeout_q, timeout_d;
  logic [INSTRUCTION_WIDTH-1:0] shift_q, shift_d;
  logic                         write_enable_q, write_enable_d;
  logic [PC_WIDTH-1:0]          write_address_q, write_address_d;
  logic [INSTRUCTION_WIDTH-1:0] write_data_q, write_data_d;
  logic                         cpu_hold_q, cpu_hold_d;
  logic                         load_done_q, load_done_d;
  logic                         load_error_q, load_error_d;
  logic [INSTRUCTION_WIDTH-1:0] word_next;
  logic                         in_frame;

  // State register and all registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (isReset) begin
      state_q         <= IDLE;
      byte_cnt_q      <= '0;
      word_cnt_q      <= '0;
      word_total_q    <= '0;
      checksum_q      <= '0;
      timeout_q       <= '0;
      shift_q         <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      cpu_hold_q      <= 1'b0;
      load_done_q     <= 1'b0;
      load_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      word_cnt_q      <= word_cnt_d;
      word_total_q    <= word_total_d;
      checksum_q      <= checksum_d;
      timeout_q       <= timeout_d;
      shift_q         <= shift_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      cpu_hold_q      <= cpu_hold_d;
      load_done_q     <= load_done_d;
      load_error_q    <= load_error_d;
    end
  end

  // Next-state logic: frame parsing, word assembly, checksum and inter-byte timeout.
  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    word_cnt_d      = word_cnt_q;
    word_total_d    = word_total_q;
    checksum_d      = checksum_q;
    timeout_d       = timeout_q;
    shift_d         = shift_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    cpu_hold_d      = cpu_hold_q;
    load_done_d     = 1'b0;
    load_error_d    = load_error_q;

    word_next = (shift_q << 8) | INSTRUCTION_WIDTH'(bus.byteIn);
    in_frame  = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);

    // A byte always restarts the idle count. The timeout only acts on a
    // cycle with no byte, so a byte landing on the expiry cycle wins.
    if (in_frame) begin
      if (bus.byteValid) begin
        timeout_d = '0;
      end else if (timeout_q == TIMEOUT_LAST) begin
        state_d      = ERROR;
        load_error_d = 1'b1;
        timeout_d    = '0;
        shift_d      = '0;
        byte_cnt_d   = '0;
      end else begin
        timeout_d = timeout_q + 1'b1;
      end
    end

    case (state_q)
      IDLE, ERROR: begin
        // ERROR differs from IDLE only in keeping cpuHold and loadError set.
        if (bus.byteValid && (bus.byteIn == START_BYTE)) begin
          state_d      = COUNT;
          cpu_hold_d   = 1'b1;
          load_error_d = 1'b0;
          timeout_d    = '0;
        end
      end
      COUNT: begin
        if (bus.byteValid) begin
          word_total_d = WORD_CNT_W'(bus.byteIn);
          checksum_d   = bus.byteIn;
          word_cnt_d   = '0;
          byte_cnt_d   = '0;
          shift_d      = '0;
          state_d      = (bus.byteIn == 8'h00) ? CHECK : DATA;
        end
      end
      DATA: begin
        if (bus.byteValid) begin
          checksum_d = checksum_q ^ bus.byteIn;
          shift_d    = word_next;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d      = '0;
            write_enable_d  = 1'b1;
            write_data_d    = word_next;
            write_address_d = word_cnt_q[PC_WIDTH-1:0];
            word_cnt_d      = word_cnt_q + 1'b1;
            if ((word_cnt_q + 1'b1) == word_total_q) begin
              state_d = CHECK;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      CHECK: begin
        if (bus.byteValid) begin
          if (bus.byteIn == checksum_q) begin
            state_d     = IDLE;
            cpu_hold_d  = 1'b0;
            load_done_d = 1'b1;
          end else begin
            state_d      = ERROR;
            load_error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.writeEnable  = write_enable_q;
  assign bus.writeAddress = write_address_q;
  assign bus.writeData    = write_data_q;
  assign bus.cpuHold      = cpu_hold_q;
  assign bus.loadDone     = load_done_q;
  assign bus.loadError    = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. It covers nominal load, bad
// checksum and recovery, empty program, inter-byte timeout and mid-frame
// reset. Expected values are hand-computed.
module tb_program_loader;

  logic clock;
  logic isReset;
  int   errors;
  int   checks;
  int   wr_count;
  int   done_count;

  program_loader_if #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(32)) bus ();

  program_loader #(
    .PC_WIDTH(8),
    .INSTRUCTION_WIDTH(32),
    .START_BYTE(8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .isReset(isReset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count write strobes and done pulses as the edge sees them.
  always @(posedge clock) begin
    if (bus.writeEnable === 1'b1) wr_count <= wr_count + 1;
    if (bus.loadDone === 1'b1) done_count <= done_count + 1;
  end

  // One byte in one clock; returns 1 ns after the capturing edge.
  task automatic send(input logic [7:0] b);
    @(negedge clock);
    bus.byteValid = 1'b1;
    bus.byteIn    = b;
    @(posedge clock);
    #1;
    bus.byteValid = 1'b0;
    $display("  byte 0x%02h -> we=%0b addr=%0d data=%08h hold=%0b done=%0b err=%0b",
             b, bus.writeEnable, bus.writeAddress, bus.writeData,
             bus.cpuHold, bus.loadDone, bus.loadError);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    isReset = 1'b1;
    bus.byteValid = 1'b0;
    bus.byteIn = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    isReset = 1'b0;
    checks++;
    if ({bus.writeEnable, bus.cpuHold, bus.loadDone, bus.loadError} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 0000",
               {bus.writeEnable, bus.cpuHold, bus.loadDone, bus.loadError});
    end
    checks++;
    if ({bus.writeAddress, bus.writeData} !== 40'h0) begin
      errors++;
      $display("FAIL reset_addr_data got %h expected 0", {bus.writeAddress, bus.writeData});
    end
  endtask

  task automatic test_nominal();
    int base_wr;
    int base_done;
    base_wr = wr_count;
    base_done = done_count;
    send(8'hA5);
    checks++;
    if (bus.cpuHold !== 1'b1) begin
      errors++;
      $display("FAIL nominal_hold_after_start got %b expected 1", bus.cpuHold);
    end
    send(8'h02);
    send(8'h01); send(8'h02); send(8'h03);
    checks++;
    if (bus.writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL nominal_early_strobe got %b expected 0", bus.writeEnable);
    end
    send(8'h04);
    checks++;
    if ({bus.writeEnable, bus.writeAddress, bus.writeData} !== {1'b1, 8'd0, 32'h01020304}) begin
      errors++;
      $display("FAIL nominal_word0 got we=%b addr=%0d data=%h expected we=1 addr=0 data=01020304",
               bus.writeEnable, bus.writeAddress, bus.writeData);
    end
    send(8'h11);
    checks++;
    if ({bus.writeEnable, bus.writeAddress, bus.writeData} !== {1'b0, 8'd0, 32'h01020304}) begin
      errors++;
      $display("FAIL nominal_strobe_width_hold got we=%b addr=%0d data=%h expected we=0 addr=0 data=01020304",
               bus.writeEnable, bus.writeAddress, bus.writeData);
    end
    send(8'h22); send(8'h33); send(8'h44);
    checks++;
    if ({bus.writeEnable, bus.writeAddress, bus.writeData} !== {1'b1, 8'd1, 32'h11223344}) begin
      errors++;
      $display("FAIL nominal_word1 got we=%b addr=%0d data=%h expected we=1 addr=1 data=11223344",
               bus.writeEnable, bus.writeAddress, bus.writeData);
    end
    // 02^01^02^03^04^11^22^33^44 = 42
    send(8'h42);
    checks++;
    if ({bus.loadDone, bus.cpuHold, bus.loadError} !== 3'b100) begin
      errors++;
      $display("FAIL nominal_done got done/hold/err=%b expected 100",
               {bus.loadDone, bus.cpuHold, bus.loadError});
    end
    idle(2);
    checks++;
    if ({wr_count - base_wr, done_count - base_done} !== {32'd2, 32'd1}) begin
      errors++;
      $display("FAIL nominal_counts got writes=%0d dones=%0d expected writes=2 dones=1",
               wr_count - base_wr, done_count - base_done);
    end
  endtask

  task automatic test_bad_checksum();
    int base_wr;
    int base_done;
    base_wr = wr_count;
    base_done = done_count;
    send(8'hA5); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h03);
    idle(3);
    checks++;
    if ({bus.cpuHold, bus.loadError} !== 2'b11) begin
      errors++;
      $display("FAIL badsum_error got hold/err=%b expected 11", {bus.cpuHold, bus.loadError});
    end
    checks++;
    if ({wr_count - base_wr, done_count - base_done} !== {32'd2, 32'd0}) begin
      errors++;
      $display("FAIL badsum_counts got writes=%0d dones=%0d expected writes=2 dones=0",
               wr_count - base_wr, done_count - base_done);
    end
    // Recovery frame; the A5 inside the data is plain data.
    send(8'hA5);
    checks++;
    if ({bus.cpuHold, bus.loadError} !== 2'b10) begin
      errors++;
      $display("FAIL recover_start got hold/err=%b expected 10", {bus.cpuHold, bus.loadError});
    end
    send(8'h01);
    send(8'hA5); send(8'h0B); send(8'h0C); send(8'h0D);
    checks++;
    if ({bus.writeEnable, bus.writeAddress, bus.writeData} !== {1'b1, 8'd0, 32'hA50B0C0D}) begin
      errors++;
      $display("FAIL recover_word got we=%b addr=%0d data=%h expected we=1 addr=0 data=a50b0c0d",
               bus.writeEnable, bus.writeAddress, bus.writeData);
    end
    // 01^A5^0B^0C^0D = AE
    send(8'hAE);
    checks++;
    if ({bus.loadDone, bus.cpuHold, bus.loadError} !== 3'b100) begin
      errors++;
      $display("FAIL recover_done got done/hold/err=%b expected 100",
               {bus.loadDone, bus.cpuHold, bus.loadError});
    end
    idle(1);
  endtask

  task automatic test_empty();
    int base_wr;
    base_wr = wr_count;
    send(8'hA5); send(8'h00); send(8'h00);
    checks++;
    if ({bus.loadDone, bus.cpuHold} !== 2'b10) begin
      errors++;
      $display("FAIL empty_done got done/hold=%b expected 10", {bus.loadDone, bus.cpuHold});
    end
    idle(2);
    checks++;
    if (wr_count - base_wr !== 0) begin
      errors++;
      $display("FAIL empty_writes got %0d expected 0", wr_count - base_wr);
    end
  endtask

  task automatic test_timeout();
    int base_wr;
    base_wr = wr_count;
    send(8'hA5); send(8'h01); send(8'hAA); send(8'hBB);
    idle(15);
    checks++;
    if ({bus.cpuHold, bus.loadError} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_early got hold/err=%b expected 10", {bus.cpuHold, bus.loadError});
    end
    idle(1);
    checks++;
    if ({bus.cpuHold, bus.loadError} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_expire got hold/err=%b expected 11", {bus.cpuHold, bus.loadError});
    end
    // Completing the old word now must not write; the frame is gone.
    send(8'hCC); send(8'hDD);
    idle(1);
    checks++;
    if (wr_count - base_wr !== 0) begin
      errors++;
      $display("FAIL timeout_writes got %0d expected 0", wr_count - base_wr);
    end
    // A byte arriving on the 16th idle cycle wins over the timeout.
    send(8'hA5); send(8'h01); send(8'hAA); send(8'hBB);
    idle(15);
    send(8'hCC);
    checks++;
    if (bus.loadError !== 1'b0) begin
      errors++;
      $display("FAIL timeout_byte_wins got err=%b expected 0", bus.loadError);
    end
    send(8'hDD);
    checks++;
    if ({bus.writeEnable, bus.writeAddress, bus.writeData} !== {1'b1, 8'd0, 32'hAABBCCDD}) begin
      errors++;
      $display("FAIL timeout_late_word got we=%b addr=%0d data=%h expected we=1 addr=0 data=aabbccdd",
               bus.writeEnable, bus.writeAddress, bus.writeData);
    end
    // 01^AA^BB^CC^DD = 01
    send(8'h01);
    checks++;
    if ({bus.loadDone, bus.cpuHold, bus.loadError} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_late_done got done/hold/err=%b expected 100",
               {bus.loadDone, bus.cpuHold, bus.loadError});
    end
    idle(1);
  endtask

  task automatic test_garbage_reset();
    int base_wr;
    base_wr = wr_count;
    send(8'h00); send(8'hFF); send(8'h5A);
    checks++;
    if ({bus.cpuHold, bus.loadError, bus.writeEnable} !== 3'b000) begin
      errors++;
      $display("FAIL garbage_idle got hold/err/we=%b expected 000",
               {bus.cpuHold, bus.loadError, bus.writeEnable});
    end
    send(8'hA5); send(8'h01); send(8'h12);
    checks++;
    if (bus.cpuHold !== 1'b1) begin
      errors++;
      $display("FAIL midframe_hold got %b expected 1", bus.cpuHold);
    end
    @(negedge clock);
    isReset = 1'b1;
    @(posedge clock);
    #1;
    isReset = 1'b0;
    checks++;
    if (bus.cpuHold !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_hold got %b expected 0", bus.cpuHold);
    end
    send(8'h34); send(8'h56); send(8'h78);
    idle(1);
    checks++;
    if (wr_count - base_wr !== 0) begin
      errors++;
      $display("FAIL reset_no_write got %0d expected 0", wr_count - base_wr);
    end
    // An empty frame proves the loader is back in IDLE.
    send(8'hA5); send(8'h00); send(8'h00);
    checks++;
    if ({bus.loadDone, bus.cpuHold} !== 2'b10) begin
      errors++;
      $display("FAIL reset_then_idle got done/hold=%b expected 10", {bus.loadDone, bus.cpuHold});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    wr_count = 0;
    done_count = 0;
    isReset = 1'b1;
    bus.byteValid = 1'b0;
    bus.byteIn = 8'h00;
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_empty();
    test_timeout();
    test_garbage_reset();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

endmodule
